// File: rtl/myipll_axil_arbiter.sv
// Two-requester round-robin arbiter onto a single AXI4-Lite master port, one transfer in flight.
// Optional per-requester accept counters when MYIPLL_ARB_STATS_EN is defined.
module myipll_axil_arbiter #(
    parameter int unsigned ADDR_WIDTH = 4,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                      ACLK,
    input  logic                      ARESETN,
    input  logic [1:0]                REQ_VALID,
    output logic [1:0]                REQ_READY,
    input  logic [1:0]                REQ_WR,
    input  logic [2*ADDR_WIDTH-1:0]   REQ_ADDR,
    input  logic [2*DATA_WIDTH-1:0]   REQ_WDATA,
    output logic [1:0]                RSP_VALID,
    output logic [DATA_WIDTH-1:0]     RSP_RDATA,
    output logic [1:0]                RSP_RESP,
    output logic [ADDR_WIDTH-1:0]     M_AXI_AWADDR,
    output logic [2:0]                M_AXI_AWPROT,
    output logic                      M_AXI_AWVALID,
    input  logic                      M_AXI_AWREADY,
    output logic [DATA_WIDTH-1:0]     M_AXI_WDATA,
    output logic [DATA_WIDTH/8-1:0]   M_AXI_WSTRB,
    output logic                      M_AXI_WVALID,
    input  logic                      M_AXI_WREADY,
    input  logic [1:0]                M_AXI_BRESP,
    input  logic                      M_AXI_BVALID,
    output logic                      M_AXI_BREADY,
    output logic [ADDR_WIDTH-1:0]     M_AXI_ARADDR,
    output logic [2:0]                M_AXI_ARPROT,
    output logic                      M_AXI_ARVALID,
    input  logic                      M_AXI_ARREADY,
    input  logic [DATA_WIDTH-1:0]     M_AXI_RDATA,
    input  logic [1:0]                M_AXI_RRESP,
    input  logic                      M_AXI_RVALID,
    output logic                      M_AXI_RREADY
`ifdef MYIPLL_ARB_STATS_EN
    ,
    output logic [15:0]               GRANT_CNT0,
    output logic [15:0]               GRANT_CNT1
`endif
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_ADDR = 3'd1,
        WR_RESP = 3'd2,
        RD_ADDR = 3'd3,
        RD_DATA = 3'd4,
        RESP    = 3'd5
    } state_e;

    state_e                  state_q, state_d;
    logic                    grant_q, grant_d;
    logic                    last_grant_q, last_grant_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic                    awvalid_q, awvalid_d;
    logic                    wvalid_q, wvalid_d;
    logic                    arvalid_q, arvalid_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic [1:0]              resp_q, resp_d;

    logic                    grant_c;
    logic                    accept_c;

    // Round-robin pick; on a tie the requester that did not win last time goes first
    always_comb begin
        grant_c = 1'b0;
        case (REQ_VALID)
            2'b10:   grant_c = 1'b1;
            2'b11:   grant_c = ~last_grant_q;
            default: grant_c = 1'b0;
        endcase
        REQ_READY = 2'b00;
        if (ARESETN && (state_q == IDLE)) begin
            REQ_READY = REQ_VALID & (grant_c ? 2'b10 : 2'b01);
        end
        accept_c = |REQ_READY;
    end

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        awvalid_d    = awvalid_q;
        wvalid_d     = wvalid_q;
        arvalid_d    = arvalid_q;
        rdata_d      = rdata_q;
        resp_d       = resp_q;
        case (state_q)
            IDLE: begin
                if (accept_c) begin
                    grant_d      = grant_c;
                    last_grant_d = grant_c;
                    addr_d       = grant_c ? REQ_ADDR[2*ADDR_WIDTH-1:ADDR_WIDTH] : REQ_ADDR[ADDR_WIDTH-1:0];
                    wdata_d      = grant_c ? REQ_WDATA[2*DATA_WIDTH-1:DATA_WIDTH] : REQ_WDATA[DATA_WIDTH-1:0];
                    rdata_d      = '0;
                    if (REQ_WR[grant_c]) begin
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        state_d   = WR_ADDR;
                    end else begin
                        arvalid_d = 1'b1;
                        state_d   = RD_ADDR;
                    end
                end
            end
            // AW and W complete independently; leave only when both are done
            WR_ADDR: begin
                awvalid_d = awvalid_q & ~M_AXI_AWREADY;
                wvalid_d  = wvalid_q & ~M_AXI_WREADY;
                if (!awvalid_d && !wvalid_d) begin
                    state_d = WR_RESP;
                end
            end
            WR_RESP: begin
                if (M_AXI_BVALID) begin
                    resp_d  = M_AXI_BRESP;
                    state_d = RESP;
                end
            end
            RD_ADDR: begin
                arvalid_d = arvalid_q & ~M_AXI_ARREADY;
                if (!arvalid_d) begin
                    state_d = RD_DATA;
                end
            end
            RD_DATA: begin
                if (M_AXI_RVALID) begin
                    rdata_d = M_AXI_RDATA;
                    resp_d  = M_AXI_RRESP;
                    state_d = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            state_q      <= IDLE;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
            addr_q       <= '0;
            wdata_q      <= '0;
            awvalid_q    <= 1'b0;
            wvalid_q     <= 1'b0;
            arvalid_q    <= 1'b0;
            rdata_q      <= '0;
            resp_q       <= 2'b00;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            awvalid_q    <= awvalid_d;
            wvalid_q     <= wvalid_d;
            arvalid_q    <= arvalid_d;
            rdata_q      <= rdata_d;
            resp_q       <= resp_d;
        end
    end

    assign M_AXI_AWADDR  = addr_q;
    assign M_AXI_AWPROT  = 3'b000;
    assign M_AXI_AWVALID = awvalid_q;
    assign M_AXI_WDATA   = wdata_q;
    assign M_AXI_WSTRB   = '1;
    assign M_AXI_WVALID  = wvalid_q;
    assign M_AXI_BREADY  = (state_q == WR_RESP);
    assign M_AXI_ARADDR  = addr_q;
    assign M_AXI_ARPROT  = 3'b000;
    assign M_AXI_ARVALID = arvalid_q;
    assign M_AXI_RREADY  = (state_q == RD_DATA);

    assign RSP_VALID = (state_q == RESP) ? (grant_q ? 2'b10 : 2'b01) : 2'b00;
    assign RSP_RDATA = rdata_q;
    assign RSP_RESP  = resp_q;

`ifdef MYIPLL_ARB_STATS_EN
    logic [15:0] cnt0_q, cnt0_d;
    logic [15:0] cnt1_q, cnt1_d;

    // Saturating accept counters
    always_comb begin
        cnt0_d = cnt0_q;
        cnt1_d = cnt1_q;
        if (accept_c && !grant_c && (cnt0_q != 16'hFFFF)) begin
            cnt0_d = cnt0_q + 16'd1;
        end
        if (accept_c && grant_c && (cnt1_q != 16'hFFFF)) begin
            cnt1_d = cnt1_q + 16'd1;
        end
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            cnt0_q <= 16'd0;
            cnt1_q <= 16'd0;
        end else begin
            cnt0_q <= cnt0_d;
            cnt1_q <= cnt1_d;
        end
    end

    assign GRANT_CNT0 = cnt0_q;
    assign GRANT_CNT1 = cnt1_q;
`endif

endmodule

// File: tb/tb_myipll_axil_arbiter.sv
// Scoreboard bench for myipll_axil_arbiter: requester drivers, AXI4-Lite slave model, response checker.
module tb_myipll_axil_arbiter;

    logic        ACLK = 1'b0;
    logic        ARESETN;
    logic [1:0]  REQ_VALID;
    logic [1:0]  REQ_READY;
    logic [1:0]  REQ_WR;
    logic [7:0]  REQ_ADDR;
    logic [63:0] REQ_WDATA;
    logic [1:0]  RSP_VALID;
    logic [31:0] RSP_RDATA;
    logic [1:0]  RSP_RESP;
    logic [3:0]  M_AXI_AWADDR;
    logic [2:0]  M_AXI_AWPROT;
    logic        M_AXI_AWVALID;
    logic        M_AXI_AWREADY;
    logic [31:0] M_AXI_WDATA;
    logic [3:0]  M_AXI_WSTRB;
    logic        M_AXI_WVALID;
    logic        M_AXI_WREADY;
    logic [1:0]  M_AXI_BRESP;
    logic        M_AXI_BVALID;
    logic        M_AXI_BREADY;
    logic [3:0]  M_AXI_ARADDR;
    logic [2:0]  M_AXI_ARPROT;
    logic        M_AXI_ARVALID;
    logic        M_AXI_ARREADY;
    logic [31:0] M_AXI_RDATA;
    logic [1:0]  M_AXI_RRESP;
    logic        M_AXI_RVALID;
    logic        M_AXI_RREADY;
`ifdef MYIPLL_ARB_STATS_EN
    logic [15:0] GRANT_CNT0;
    logic [15:0] GRANT_CNT1;
`endif

    myipll_axil_arbiter #(.ADDR_WIDTH(4), .DATA_WIDTH(32)) dut (
        .ACLK(ACLK), .ARESETN(ARESETN),
        .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY), .REQ_WR(REQ_WR),
        .REQ_ADDR(REQ_ADDR), .REQ_WDATA(REQ_WDATA),
        .RSP_VALID(RSP_VALID), .RSP_RDATA(RSP_RDATA), .RSP_RESP(RSP_RESP),
        .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWPROT(M_AXI_AWPROT),
        .M_AXI_AWVALID(M_AXI_AWVALID), .M_AXI_AWREADY(M_AXI_AWREADY),
        .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB),
        .M_AXI_WVALID(M_AXI_WVALID), .M_AXI_WREADY(M_AXI_WREADY),
        .M_AXI_BRESP(M_AXI_BRESP), .M_AXI_BVALID(M_AXI_BVALID), .M_AXI_BREADY(M_AXI_BREADY),
        .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARPROT(M_AXI_ARPROT),
        .M_AXI_ARVALID(M_AXI_ARVALID), .M_AXI_ARREADY(M_AXI_ARREADY),
        .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP),
        .M_AXI_RVALID(M_AXI_RVALID), .M_AXI_RREADY(M_AXI_RREADY)
`ifdef MYIPLL_ARB_STATS_EN
        , .GRANT_CNT0(GRANT_CNT0), .GRANT_CNT1(GRANT_CNT1)
`endif
    );

    always #5 ACLK = ~ACLK;

    typedef struct {
        logic        wr;
        logic [3:0]  addr;
        logic [31:0] wdata;
    } cmd_t;

    typedef struct {
        logic        idx;
        logic        wr;
        logic [31:0] rdata;
        logic [1:0]  resp;
        int          acc_cyc;
        int          lat;
        int          aw_n;
        int          w_n;
        int          ar_n;
    } exp_t;

    cmd_t        cmdq0[$];
    cmd_t        cmdq1[$];
    exp_t        sb[$];
    logic [31:0] ref_mem[4];
    logic [31:0] slv_mem[4];
    int          n_checks = 0;
    int          n_errors = 0;
    int          d_aw = 0, d_w = 0, d_ar = 0, d_r = 0;
    int          cyc = 0;
    int          acc_cnt[2];
    int          aw_hi = 0, w_hi = 0, ar_hi = 0, viol = 0;
    logic        lg;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    task automatic push_cmd(input int r, input logic wr, input logic [3:0] a, input logic [31:0] d);
        cmd_t c;
        c.wr = wr;
        c.addr = a;
        c.wdata = d;
        if (r == 0) cmdq0.push_back(c);
        else        cmdq1.push_back(c);
    endtask

    // Per-cycle engine: sample at negedge, drive just after posedge
    initial begin : bus_loop
        logic [1:0]  hs;
        logic        aw_hs, w_hs, b_hs, ar_hs, r_hs, rst_seen, exp_g;
        logic        p_awv, p_wv, p_arv, p_awhs, p_whs, p_arhs;
        logic [3:0]  p_awaddr, p_araddr, s_awaddr, s_araddr;
        logic [31:0] p_wdata, s_wdata;
        logic        s_aw_done, s_w_done, s_ar_done;
        int          aw_wait, w_wait, ar_wait, r_wait;
        cmd_t        c;
        exp_t        e;
        REQ_VALID = 2'b00; REQ_WR = 2'b00; REQ_ADDR = '0; REQ_WDATA = '0;
        M_AXI_AWREADY = 1'b0; M_AXI_WREADY = 1'b0; M_AXI_ARREADY = 1'b0;
        M_AXI_BVALID = 1'b0; M_AXI_BRESP = 2'b00;
        M_AXI_RVALID = 1'b0; M_AXI_RDATA = '0; M_AXI_RRESP = 2'b00;
        for (int i = 0; i < 4; i++) begin
            ref_mem[i] = '0;
            slv_mem[i] = '0;
        end
        lg = 1'b1; acc_cnt[0] = 0; acc_cnt[1] = 0;
        {p_awv, p_wv, p_arv, p_awhs, p_whs, p_arhs} = '0;
        p_awaddr = '0; p_araddr = '0; p_wdata = '0;
        {s_aw_done, s_w_done, s_ar_done} = '0;
        s_awaddr = '0; s_araddr = '0; s_wdata = '0;
        aw_wait = 0; w_wait = 0; ar_wait = 0; r_wait = 0;
        forever begin
            @(negedge ACLK);
            cyc++;
            rst_seen = !ARESETN;
            hs = 2'b00;
            {aw_hs, w_hs, b_hs, ar_hs, r_hs} = '0;
            if (rst_seen) begin
                sb.delete();
                lg = 1'b1; acc_cnt[0] = 0; acc_cnt[1] = 0;
                {p_awv, p_wv, p_arv, p_awhs, p_whs, p_arhs} = '0;
                {s_aw_done, s_w_done, s_ar_done} = '0;
                aw_wait = 0; w_wait = 0; ar_wait = 0; r_wait = 0;
            end else begin
                if (M_AXI_BREADY && (M_AXI_AWVALID || M_AXI_WVALID)) viol++;
                if (M_AXI_RREADY && M_AXI_ARVALID) viol++;
                if (p_awv && !p_awhs && (!M_AXI_AWVALID || M_AXI_AWADDR != p_awaddr)) viol++;
                if (p_wv && !p_whs && (!M_AXI_WVALID || M_AXI_WDATA != p_wdata)) viol++;
                if (p_arv && !p_arhs && (!M_AXI_ARVALID || M_AXI_ARADDR != p_araddr)) viol++;
                if (M_AXI_AWVALID) aw_hi++;
                if (M_AXI_WVALID)  w_hi++;
                if (M_AXI_ARVALID) ar_hi++;
                if (RSP_VALID != 2'b00) begin
                    if (sb.size() == 0) begin
                        check_val("rsp_unexpected", 32'(RSP_VALID), 32'd0);
                    end else begin
                        e = sb.pop_front();
                        check_val("rsp_idx", 32'(RSP_VALID), e.idx ? 32'd2 : 32'd1);
                        check_val("rsp_rdata", RSP_RDATA, e.rdata);
                        check_val("rsp_resp", 32'(RSP_RESP), 32'(e.resp));
                        check_val("rsp_latency", 32'(cyc - e.acc_cyc), 32'(e.lat));
                        if (e.wr) begin
                            check_val("awvalid_cycles", 32'(aw_hi), 32'(e.aw_n));
                            check_val("wvalid_cycles", 32'(w_hi), 32'(e.w_n));
                        end else begin
                            check_val("arvalid_cycles", 32'(ar_hi), 32'(e.ar_n));
                        end
                        check_val("axi_protocol", 32'(viol), 32'd0);
                    end
                end
                hs = REQ_VALID & REQ_READY;
                if (hs != 2'b00) begin
                    exp_g = (REQ_VALID == 2'b11) ? ~lg : REQ_VALID[1];
                    check_val("grant", 32'(hs), exp_g ? 32'd2 : 32'd1);
                    c = hs[1] ? cmdq1[0] : cmdq0[0];
                    e.idx = hs[1];
                    e.wr = c.wr;
                    if (c.wr) begin
                        e.rdata = '0;
                        if (c.addr == 4'hC) begin
                            e.resp = 2'b10;
                        end else begin
                            e.resp = 2'b00;
                            ref_mem[c.addr[3:2]] = c.wdata;
                        end
                        e.lat = 3 + ((d_aw > d_w) ? d_aw : d_w);
                    end else begin
                        e.rdata = ref_mem[c.addr[3:2]];
                        e.resp = 2'b00;
                        e.lat = 3 + d_ar + d_r;
                    end
                    e.acc_cyc = cyc;
                    e.aw_n = 1 + d_aw;
                    e.w_n = 1 + d_w;
                    e.ar_n = 1 + d_ar;
                    aw_hi = 0; w_hi = 0; ar_hi = 0;
                    lg = hs[1];
                    acc_cnt[hs[1]]++;
                    sb.push_back(e);
                end
                aw_hs = M_AXI_AWVALID && M_AXI_AWREADY;
                w_hs  = M_AXI_WVALID && M_AXI_WREADY;
                ar_hs = M_AXI_ARVALID && M_AXI_ARREADY;
                b_hs  = M_AXI_BVALID && M_AXI_BREADY;
                r_hs  = M_AXI_RVALID && M_AXI_RREADY;
                if (M_AXI_AWVALID && !M_AXI_AWREADY) aw_wait++;
                if (M_AXI_WVALID && !M_AXI_WREADY)   w_wait++;
                if (M_AXI_ARVALID && !M_AXI_ARREADY) ar_wait++;
                if (s_ar_done && !M_AXI_RVALID)      r_wait++;
                if (aw_hs) begin s_aw_done = 1'b1; s_awaddr = M_AXI_AWADDR; end
                if (w_hs)  begin s_w_done = 1'b1;  s_wdata = M_AXI_WDATA;   end
                if (ar_hs) begin s_ar_done = 1'b1; s_araddr = M_AXI_ARADDR; end
                p_awv = M_AXI_AWVALID; p_awhs = aw_hs; p_awaddr = M_AXI_AWADDR;
                p_wv = M_AXI_WVALID;   p_whs = w_hs;   p_wdata = M_AXI_WDATA;
                p_arv = M_AXI_ARVALID; p_arhs = ar_hs; p_araddr = M_AXI_ARADDR;
            end
            @(posedge ACLK);
            #1;
            if (hs[0]) void'(cmdq0.pop_front());
            if (hs[1]) void'(cmdq1.pop_front());
            REQ_VALID[0] = (cmdq0.size() > 0);
            REQ_VALID[1] = (cmdq1.size() > 0);
            if (cmdq0.size() > 0) begin
                REQ_WR[0] = cmdq0[0].wr; REQ_ADDR[3:0] = cmdq0[0].addr; REQ_WDATA[31:0] = cmdq0[0].wdata;
            end
            if (cmdq1.size() > 0) begin
                REQ_WR[1] = cmdq1[0].wr; REQ_ADDR[7:4] = cmdq1[0].addr; REQ_WDATA[63:32] = cmdq1[0].wdata;
            end
            if (rst_seen) begin
                {M_AXI_AWREADY, M_AXI_WREADY, M_AXI_ARREADY, M_AXI_BVALID, M_AXI_RVALID} = '0;
            end else begin
                if (aw_hs) aw_wait = 0;
                if (w_hs)  w_wait = 0;
                if (ar_hs) ar_wait = 0;
                M_AXI_AWREADY = M_AXI_AWVALID && !s_aw_done && (aw_wait >= d_aw);
                M_AXI_WREADY  = M_AXI_WVALID && !s_w_done && (w_wait >= d_w);
                M_AXI_ARREADY = M_AXI_ARVALID && !s_ar_done && (ar_wait >= d_ar);
                if (b_hs) M_AXI_BVALID = 1'b0;
                if (s_aw_done && s_w_done && !M_AXI_BVALID) begin
                    M_AXI_BVALID = 1'b1;
                    M_AXI_BRESP = (s_awaddr == 4'hC) ? 2'b10 : 2'b00;
                    if (s_awaddr != 4'hC) slv_mem[s_awaddr[3:2]] = s_wdata;
                    s_aw_done = 1'b0;
                    s_w_done = 1'b0;
                end
                if (r_hs) M_AXI_RVALID = 1'b0;
                if (s_ar_done && !M_AXI_RVALID && (r_wait >= d_r)) begin
                    M_AXI_RVALID = 1'b1;
                    M_AXI_RDATA = slv_mem[s_araddr[3:2]];
                    M_AXI_RRESP = 2'b00;
                    s_ar_done = 1'b0;
                    r_wait = 0;
                end
            end
        end
    end

    task automatic wait_drain();
        for (int i = 0; i < 400; i++) begin
            @(posedge ACLK);
            #1;
            if (sb.size() == 0 && cmdq0.size() == 0 && cmdq1.size() == 0 && REQ_VALID == 2'b00) break;
        end
        check_val("drain_pending", 32'(sb.size() + cmdq0.size() + cmdq1.size()), 32'd0);
        repeat (3) @(posedge ACLK);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_req_ready"}, 32'(REQ_READY), 32'd0);
        check_val({tag, "_rsp_valid"}, 32'(RSP_VALID), 32'd0);
        check_val({tag, "_rsp_rdata"}, RSP_RDATA, 32'd0);
        check_val({tag, "_rsp_resp"}, 32'(RSP_RESP), 32'd0);
        check_val({tag, "_axi_vr"}, 32'({M_AXI_AWVALID, M_AXI_WVALID, M_AXI_ARVALID, M_AXI_BREADY, M_AXI_RREADY}), 32'd0);
        check_val({tag, "_prot_strb"}, 32'({M_AXI_AWPROT, M_AXI_ARPROT, M_AXI_WSTRB}), 32'h00F);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        logic seen_rd;
        ARESETN = 1'b0;
        // Both requesters valid from reset: alternating grants, requester 0 first
        for (int i = 0; i < 4; i++) begin
            push_cmd(0, 1'b1, 4'(i * 4), 32'h100 + 32'(i));
            push_cmd(1, 1'b1, 4'(i * 4), 32'h200 + 32'(i));
        end
        repeat (3) @(posedge ACLK);
        #1;
        check_reset_outputs("rst");
        ARESETN = 1'b1;
        wait_drain();

        push_cmd(0, 1'b1, 4'h0, 32'h0000_0001);
        wait_drain();

        push_cmd(0, 1'b1, 4'h4, 32'h0000_0002);
        push_cmd(0, 1'b0, 4'h4, 32'h0);
        push_cmd(0, 1'b0, 4'h0, 32'h0);
        push_cmd(1, 1'b1, 4'hC, 32'hCAFE_F00D);
        push_cmd(1, 1'b0, 4'hC, 32'h0);
        push_cmd(1, 1'b0, 4'h8, 32'h0);
        wait_drain();

        d_aw = 3;
        push_cmd(1, 1'b1, 4'h8, 32'h0000_0033);
        wait_drain();
        d_aw = 0; d_w = 2;
        push_cmd(0, 1'b1, 4'hC, 32'h0000_0044);
        wait_drain();
        d_w = 0; d_ar = 2;
        push_cmd(0, 1'b0, 4'h8, 32'h0);
        wait_drain();
        d_ar = 0;

        // Reset while the read waits in the data phase
        d_r = 30;
        push_cmd(1, 1'b0, 4'h4, 32'h0);
        seen_rd = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(posedge ACLK);
            #1;
            if (M_AXI_RREADY) begin
                seen_rd = 1'b1;
                break;
            end
        end
        check_val("rd_data_reached", 32'(seen_rd), 32'd1);
        @(posedge ACLK);
        #1;
        ARESETN = 1'b0;
        @(posedge ACLK);
        #1;
        check_reset_outputs("midrst");
        ARESETN = 1'b1;
        d_r = 0;
        repeat (4) @(posedge ACLK);
        #1;
        push_cmd(1, 1'b0, 4'h4, 32'h0);
        wait_drain();

        for (int i = 0; i < 5; i++) push_cmd(0, 1'b1, 4'(i % 3 * 4), 32'h500 + 32'(i));
        push_cmd(1, 1'b0, 4'h0, 32'h0);
        push_cmd(1, 1'b0, 4'h4, 32'h0);
        wait_drain();
`ifdef MYIPLL_ARB_STATS_EN
        check_val("grant_cnt0", 32'(GRANT_CNT0), 32'(acc_cnt[0]));
        check_val("grant_cnt1", 32'(GRANT_CNT1), 32'(acc_cnt[1]));
`endif
        check_val("accepts_req1_after_reset", 32'(acc_cnt[1]), 32'd3);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/myipll_axil_arbiter.md
MYIPLL_AXIL_ARBITER -- requirements
Module: myipll_axil_arbiter

Interface
REQ-001 ADDR_WIDTH, 4, AXI4-Lite byte address width; covers the 4-register map 0x0-0xC.
REQ-002 DATA_WIDTH, 32, data width; only 32 is supported.
REQ-003 ACLK  in  1  sole clock; all logic on rising edge.
REQ-004 ARESETN  in  1  reset, synchronous, active-low.
REQ-005 REQ_VALID  in  2  per-requester command valid; bit r belongs to requester r.
REQ-006 REQ_READY  out  2  per-requester command accept; handshake is VALID&READY.
REQ-007 REQ_WR  in  2  per-requester command type: 1 = write, 0 = read.
REQ-008 REQ_ADDR  in  2*ADDR_WIDTH  per-requester address; requester r uses slice r.
REQ-009 REQ_WDATA  in  2*DATA_WIDTH  per-requester write data; requester r uses slice r.
REQ-010 RSP_VALID  out  2  one-cycle response strobe to the granted requester.
REQ-011 RSP_RDATA  out  DATA_WIDTH  read data, qualified by RSP_VALID; 0 for writes.
REQ-012 RSP_RESP  out  2  BRESP or RRESP of the completed transfer.
REQ-013 M_AXI_AW{ADDR,PROT,VALID}/AWREADY, W{DATA,STRB,VALID}/WREADY, B{RESP,VALID}/BREADY, AR{ADDR,PROT,VALID}/ARREADY, R{DATA,RESP,VALID}/RREADY: AXI4-Lite master port; widths per AXI4-Lite, AWPROT/ARPROT = 3'b000, WSTRB = 4'hF.

Function
REQ-014 FSM states: IDLE, WR_ADDR (AW+W phase), WR_RESP, RD_ADDR, RD_DATA, RESP; at most one transfer in flight.
REQ-015 REQ_READY is asserted only in IDLE, to the granted requester, combinationally from REQ_VALID.
REQ-016 Arbitration is round-robin: one requester valid -> it is granted; both valid -> the requester other than last_grant is granted; last_grant updates on accept.
REQ-017 On accept, the address, write data and type are registered; next state is WR_ADDR or RD_ADDR.
REQ-018 WR_ADDR: AWVALID and WVALID assert the cycle after accept; each drops independently after its own handshake; the state moves to WR_RESP only once both handshakes are done.
REQ-019 WR_RESP: BREADY = 1; on BVALID, BRESP is captured and the state moves to RESP.
REQ-020 RD_ADDR: ARVALID asserts the cycle after accept and holds until ARREADY; RD_DATA: RREADY = 1; on RVALID, RDATA and RRESP are captured and the state moves to RESP.
REQ-021 RESP: RSP_VALID[grant] = 1 for exactly one cycle, with no backpressure, then IDLE; a new accept is possible in that next IDLE cycle.
REQ-022 Minimum latency with zero-wait slave: accept at cycle 0, AW/W/AR valid at cycle 1, B/R handshake at cycle 2, RSP_VALID at cycle 3.
REQ-023 AXI VALID outputs never drop before their handshake; address and data are stable while VALID is high.
REQ-024 A requester may drop REQ_VALID before grant; the command is not executed and no response is issued.
REQ-025 Requester r's REQ_VALID asserted in the same cycle as its RSP_VALID is arbitrated normally in the next IDLE cycle.

Reset
REQ-026 ARESETN low at a clock edge: state -> IDLE; all AXI VALID/READY outputs, REQ_READY, RSP_VALID, RSP_RDATA and RSP_RESP = 0; last_grant = 1, so requester 0 wins the first tie.
REQ-027 Reset mid-transfer abandons the transfer; no RSP_VALID is issued for it.

Configuration
REQ-028 MYIPLL_ARB_STATS_EN defined: output ports GRANT_CNT0 and GRANT_CNT1 (16 bit each) count accepts per requester, saturate at 16'hFFFF, and clear on reset.
REQ-029 MYIPLL_ARB_STATS_EN undefined: the counters and their ports do not exist; all other behaviour is identical.

Verification
REQ-030 Req0 writes 0x00000001 to 0x0 with a zero-wait slave -> AW/W valid at cycle 1, RSP_VALID[0] at cycle 3, RSP_RESP = 2'b00.
REQ-031 Both requesters valid continuously from reset, 4 commands each -> grant order 0,1,0,1,...; no response on the wrong index.
REQ-032 Write 0x00000002 to 0x4, then read 0x4 -> RSP_RDATA = 0x00000002, RSP_RESP = 2'b00.
REQ-033 AWREADY delayed 3 cycles, WREADY immediate -> WVALID high 1 cycle, AWVALID high 4 cycles, BREADY asserted only after both handshakes.
REQ-034 ARESETN low for 1 cycle during RD_DATA -> all outputs 0, no RSP_VALID; the next read completes normally.
REQ-035 With MYIPLL_ARB_STATS_EN: 5 req0 and 3 req1 accepts -> GRANT_CNT0 = 5, GRANT_CNT1 = 3.
